imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 133 +++++++++++++
 tb/tb_imem_loader.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: count, little-endian words, optional checksum.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CSUM_EN.
module imem_loader #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst,
    output logic        done,
    output logic        error,
    output logic [15:0] word_cnt
);

    // state  | meaning
    // CNT_LO | waiting for N[7:0]
    // CNT_HI | waiting for N[15:8], range check
    // DATA   | assembling and writing instruction words
    // CSUM   | waiting for checksum byte (checksum build only)
    // DONE   | image loaded, core released
    // ERROR  | load failed, core held in reset
    typedef enum logic [2:0] {
        CNT_LO,
        CNT_HI,
        DATA,
`ifdef IMEM_LOADER_CSUM_EN
        CSUM,
`endif
        DONE,
        ERROR
    } state_t;

`ifdef IMEM_LOADER_CSUM_EN
    localparam state_t AFTER_DATA = CSUM;
`else
    localparam state_t AFTER_DATA = DONE;
`endif
    localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

    state_t      state, state_nxt;
    logic [15:0] n_words;
    logic [1:0]  lane;
    logic [23:0] word_buf;
    logic        accept;
    logic [15:0] n_full;
    logic        last_word;
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0]  csum;
`endif

    assign rx_ready  = !rst && (state != DONE) && (state != ERROR);
    assign accept    = rx_valid && rx_ready;
    assign n_full    = {rx_data, n_words[7:0]};
    assign last_word = (word_cnt + 16'd1) == n_words;

    always_ff @(posedge clk) begin
        if (rst) state <= CNT_LO;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        core_rst  = 1'b1;
        done      = 1'b0;
        error     = 1'b0;
        case (state)
            CNT_LO: if (accept) state_nxt = CNT_HI;
            CNT_HI: begin
                if (accept) begin
                    if ({16'h0000, n_full} > DEPTH_L) state_nxt = ERROR;
                    else if (n_full == 16'd0)         state_nxt = AFTER_DATA;
                    else                              state_nxt = DATA;
                end
            end
            DATA: if (accept && lane == 2'd3 && last_word) state_nxt = AFTER_DATA;
`ifdef IMEM_LOADER_CSUM_EN
            CSUM: if (accept) state_nxt = (rx_data == csum) ? DONE : ERROR;
`endif
            DONE: begin
                core_rst = 1'b0;
                done     = 1'b1;
            end
            ERROR: error = 1'b1;
            default: state_nxt = ERROR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_words    <= 16'd0;
            lane       <= 2'd0;
            word_buf   <= 24'd0;
            word_cnt   <= 16'd0;
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= 32'd0;
`ifdef IMEM_LOADER_CSUM_EN
            csum       <= 8'd0;
`endif
        end else begin
            imem_we <= 1'b0;
            if (accept) begin
`ifdef IMEM_LOADER_CSUM_EN
                if (state != CSUM) csum <= csum ^ rx_data;
`endif
                case (state)
                    CNT_LO: n_words[7:0]  <= rx_data;
                    CNT_HI: n_words[15:8] <= rx_data;
                    DATA: begin
                        lane <= lane + 2'd1;
                        // Earlier lanes shift down so lane 0 ends up in wdata[7:0].
                        if (lane == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_wdata <= {rx_data, word_buf};
                            imem_addr  <= BASE_ADDR + {14'd0, word_cnt, 2'b00};
                            word_cnt   <= word_cnt + 16'd1;
                        end else begin
                            word_buf <= {rx_data, word_buf[23:8]};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a stream-level reference model.
module tb_imem_loader;

    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_0000;
`ifdef IMEM_LOADER_CSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        done;
    logic        error;
    logic [15:0] word_cnt;

    imem_loader #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .core_rst(core_rst), .done(done),
        .error(error), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    int          got_cyc[$];
    int          acc_cyc[$];

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            got_addr.push_back(imem_addr);
            got_data.push_back(imem_wdata);
            got_cyc.push_back(cyc);
        end
    end

    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    bit          exp_err;
    int          exp_consumed;
    int          exp_wcnt;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model(input bq_t s);
        int n;
        logic [7:0] x;
        exp_addr.delete();
        exp_data.delete();
        n = {s[1], s[0]};
        if (n > DEPTH) begin
            exp_err = 1'b1;
            exp_consumed = 2;
            exp_wcnt = 0;
        end else begin
            for (int i = 0; i < n; i++) begin
                exp_addr.push_back(BASE + 32'(4 * i));
                exp_data.push_back({s[2+4*i+3], s[2+4*i+2], s[2+4*i+1], s[2+4*i]});
            end
            exp_consumed = 2 + 4 * n;
            exp_wcnt = n;
            exp_err = 1'b0;
            if (CSUM_ON) begin
                x = 8'h00;
                for (int j = 0; j < exp_consumed; j++) x = x ^ s[j];
                exp_err = (s[exp_consumed] != x);
                exp_consumed++;
            end
        end
    endtask

    function automatic bq_t build(input int n, input bit bad);
        bq_t s;
        logic [7:0] x;
        s.push_back(n[7:0]);
        s.push_back(n[15:8]);
        for (int i = 0; i < 4 * n; i++) s.push_back(8'($urandom));
        if (CSUM_ON) begin
            x = 8'h00;
            foreach (s[k]) x = x ^ s[k];
            s.push_back(bad ? (x ^ 8'($urandom_range(1, 255))) : x);
        end
        for (int i = 0; i < 3; i++) s.push_back(8'($urandom));
        return s;
    endfunction

    task automatic drive_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        #1;
        if (rx_ready === 1'b1) acc_cyc.push_back(cyc + 1);
        @(negedge clk);
    endtask

    task automatic idle_cycle();
        rx_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1;
        rx_valid = 1'b1;
        rx_data = 8'h5A;
        #1;
        check_val({name, "_rdy_in_rst"}, rx_ready, 1'b0);
        @(negedge clk);
        check_val({name, "_rst_outs"},
                  {imem_we, core_rst, done, error, word_cnt, imem_addr, imem_wdata},
                  {1'b0, 1'b1, 1'b0, 1'b0, 16'd0, BASE, 32'd0});
        rst = 1'b0;
        rx_valid = 1'b0;
        #1;
        check_val({name, "_rdy_after_rst"}, rx_ready, 1'b1);
        @(negedge clk);
    endtask

    task automatic run_scn(input string name, input bq_t s, input int max_gap, input bit b2b);
        int gaps;
        model(s);
        got_addr.delete();
        got_data.delete();
        got_cyc.delete();
        acc_cyc.delete();
        do_reset(name);
        foreach (s[k]) begin
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) idle_cycle();
            drive_byte(s[k]);
        end
        idle_cycle();
        idle_cycle();
        check_val({name, "_accepted"}, acc_cyc.size(), exp_consumed);
        check_val({name, "_nwrites"}, got_addr.size(), exp_addr.size());
        for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
            check_val($sformatf("%s_wr%0d_addr", name, i), got_addr[i], exp_addr[i]);
            check_val($sformatf("%s_wr%0d_data", name, i), got_data[i], exp_data[i]);
            if (2 + 4 * i + 3 < acc_cyc.size())
                check_val($sformatf("%s_wr%0d_cyc", name, i), got_cyc[i], acc_cyc[2+4*i+3]);
        end
        check_val({name, "_status"}, {done, error, core_rst, rx_ready},
                  {!exp_err, exp_err, exp_err, 1'b0});
        check_val({name, "_word_cnt"}, word_cnt, exp_wcnt);
        if (b2b) begin
            gaps = 0;
            for (int i = 1; i < acc_cyc.size(); i++)
                if (acc_cyc[i] != acc_cyc[i-1] + 1) gaps++;
            check_val({name, "_b2b_gaps"}, gaps, 0);
        end
    endtask

    initial begin
        bq_t s;
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        @(negedge clk);

        s = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC2, 8'h11, 8'h22};
        run_scn("known_good", s, 0, 1'b0);
        s = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC3, 8'h11, 8'h22};
        run_scn("known_badcs", s, 0, 1'b0);
        s = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_scn("n257", s, 0, 1'b0);
        run_scn("n3_b2b", build(3, 1'b0), 0, 1'b1);
        run_scn("n0", build(0, 1'b0), 2, 1'b0);
        run_scn("n_depth", build(DEPTH, 1'b0), 0, 1'b1);
        run_scn("n_big", build($urandom_range(DEPTH + 1, 65535), 1'b0), 1, 1'b0);

        got_addr.delete();
        do_reset("mid");
        s = '{8'h01, 8'h00, 8'hAA, 8'hBB};
        foreach (s[k]) drive_byte(s[k]);
        idle_cycle();
        check_val("mid_nowrite", got_addr.size(), 0);
        check_val("mid_wcnt", word_cnt, 16'd0);
        run_scn("mid_fresh", build(1, 1'b0), 1, 1'b0);

        for (int r = 0; r < 6; r++)
            run_scn($sformatf("rnd%0d", r), build($urandom_range(0, 8), ($urandom_range(0, 3) == 0)), 3, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
